// File: rtl/cordic_result_fifo.sv
// Result buffer behind the CORDIC core: captures every result beat into a
// first-word-fall-through FIFO and issues credits so the core is never overrun.
module cordic_result_fifo #(
    parameter int TOTAL_WIDTH = 49,
    parameter int DEPTH       = 16,
    parameter int CNT_WIDTH   = $clog2(DEPTH) + 1
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_issue,
    output logic                   o_can_issue,
    input  logic                   i_vld,
    input  logic [TOTAL_WIDTH-1:0] i_data,
    output logic                   o_vld,
    output logic [TOTAL_WIDTH-1:0] o_data,
    input  logic                   i_rdy,
    output logic [CNT_WIDTH-1:0]   o_count,
    output logic [CNT_WIDTH-1:0]   o_inflight,
    output logic                   o_overflow,
    output logic                   o_err
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [CNT_WIDTH-1:0] FULL_CNT   = CNT_WIDTH'(DEPTH);
    localparam logic [CNT_WIDTH:0]   CREDIT_MAX = (CNT_WIDTH + 1)'(DEPTH);

    logic [TOTAL_WIDTH-1:0] r_mem [DEPTH];
    logic [TOTAL_WIDTH-1:0] r_head;
    logic [AW-1:0]          r_wr_ptr;
    logic [AW-1:0]          r_rd_ptr;
    logic [CNT_WIDTH-1:0]   r_count;
    logic [CNT_WIDTH-1:0]   r_inflight;
    logic                   r_overflow;
    logic                   r_err;

    logic                   w_vld;
    logic                   w_rd;
    logic                   w_wr;
    logic                   w_iss;
    logic                   w_ret;
    logic                   w_full;
    logic                   w_can_issue;
    logic [CNT_WIDTH:0]     w_credit_sum;
    logic [AW-1:0]          w_rd_ptr_next;
    logic [AW-1:0]          w_wr_ptr_next;
    logic [CNT_WIDTH-1:0]   w_count_next;
    logic [CNT_WIDTH-1:0]   w_inflight_next;
    logic                   w_overflow_evt;
    logic                   w_err_evt;

    // Event decode; everything is derived from registered state and inputs.
    assign w_vld          = (r_count != '0);
    assign w_full         = (r_count == FULL_CNT);
    assign w_rd           = w_vld & i_rdy;
    assign w_wr           = i_vld & (~w_full | w_rd);
    assign w_ret          = i_vld;
    assign w_credit_sum   = {1'b0, r_count} + {1'b0, r_inflight};
    assign w_can_issue    = (w_credit_sum < CREDIT_MAX);
    assign w_iss          = i_issue & w_can_issue;
    assign w_overflow_evt = i_vld & w_full & ~w_rd;
    assign w_err_evt      = (i_issue & ~w_can_issue) | (w_ret & (r_inflight == '0));

    assign w_rd_ptr_next  = r_rd_ptr + AW'(w_rd);
    assign w_wr_ptr_next  = r_wr_ptr + AW'(w_wr);

    always_comb begin
        w_count_next = r_count;
        case ({w_wr, w_rd})
            2'b10:   w_count_next = r_count + 1'b1;
            2'b01:   w_count_next = r_count - 1'b1;
            default: w_count_next = r_count;
        endcase
    end

    // A return with nothing in flight is a protocol error; the counter saturates at 0.
    always_comb begin
        w_inflight_next = r_inflight;
        case ({w_iss, w_ret})
            2'b10:   w_inflight_next = r_inflight + 1'b1;
            2'b01:   w_inflight_next = (r_inflight != '0) ? r_inflight - 1'b1 : r_inflight;
            default: w_inflight_next = r_inflight;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst && w_wr) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Registered read of the next head; bypass covers a write landing on that slot.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_head <= '0;
        end else if (w_wr && (r_wr_ptr == w_rd_ptr_next)) begin
            r_head <= i_data;
        end else begin
            r_head <= r_mem[w_rd_ptr_next];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_inflight <= '0;
            r_overflow <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_wr_ptr   <= w_wr_ptr_next;
            r_rd_ptr   <= w_rd_ptr_next;
            r_count    <= w_count_next;
            r_inflight <= w_inflight_next;
            r_overflow <= r_overflow | w_overflow_evt;
            r_err      <= r_err | w_err_evt;
        end
    end

    assign o_vld       = w_vld;
    assign o_data      = w_vld ? r_head : '0;
    assign o_count     = r_count;
    assign o_inflight  = r_inflight;
    assign o_can_issue = w_can_issue;
    assign o_overflow  = r_overflow;
    assign o_err       = r_err;

endmodule

// File: tb/tb_cordic_result_fifo.sv
// Bench for cordic_result_fifo: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized legal traffic.
module tb_cordic_result_fifo;

    localparam int W     = 49;
    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int LAT   = 6;

    logic          clk;
    logic          i_rst;
    logic          i_issue;
    logic          o_can_issue;
    logic          i_vld;
    logic [W-1:0]  i_data;
    logic          o_vld;
    logic [W-1:0]  o_data;
    logic          i_rdy;
    logic [CW-1:0] o_count;
    logic [CW-1:0] o_inflight;
    logic          o_overflow;
    logic          o_err;

    cordic_result_fifo #(.TOTAL_WIDTH(W), .DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
        .i_clk(clk), .i_rst(i_rst), .i_issue(i_issue), .o_can_issue(o_can_issue),
        .i_vld(i_vld), .i_data(i_data), .o_vld(o_vld), .o_data(o_data),
        .i_rdy(i_rdy), .o_count(o_count), .o_inflight(o_inflight),
        .o_overflow(o_overflow), .o_err(o_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: a queue of buffered words plus plain counters.
    logic [W-1:0] m_q[$];
    int           m_infl = 0;
    bit           m_ovf  = 0;
    bit           m_err  = 0;
    bit           started = 0;

    function automatic bit mcan();
        return (m_q.size() + m_infl) < DEPTH;
    endfunction

    always @(posedge clk) begin
        if (i_rst) begin
            m_q.delete();
            m_infl = 0;
            m_ovf  = 0;
            m_err  = 0;
        end else begin
            bit rd, wr, can, iss;
            rd  = (m_q.size() != 0) && i_rdy;
            can = mcan();
            wr  = i_vld && ((m_q.size() < DEPTH) || rd);
            iss = i_issue && can;
            if (i_vld && !wr) m_ovf = 1;
            if (i_issue && !can) m_err = 1;
            if (i_vld && m_infl == 0) m_err = 1;
            if (rd) void'(m_q.pop_front());
            if (wr) m_q.push_back(i_data);
            if (iss && !i_vld) m_infl++;
            else if (!iss && i_vld && m_infl > 0) m_infl--;
        end
        started = 1;
    end

    always @(negedge clk) begin
        if (started) begin
            chk("m_vld", 64'(o_vld), 64'(m_q.size() != 0));
            chk("m_data", 64'(o_data), (m_q.size() != 0) ? 64'(m_q[0]) : 64'd0);
            chk("m_count", 64'(o_count), 64'(m_q.size()));
            chk("m_inflight", 64'(o_inflight), 64'(m_infl));
            chk("m_can_issue", 64'(o_can_issue), 64'(mcan()));
            chk("m_overflow", 64'(o_overflow), 64'(m_ovf));
            chk("m_err", 64'(o_err), 64'(m_err));
        end
    end

    int cyc = 0;
    int ret_at[$];
    int seq = 0;
    bit rnd_data = 0;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // One cycle of an emulated core with fixed latency; issues only when credit allows.
    task automatic drive(input bit want, input bit rdy);
        i_issue = want && mcan();
        if (i_issue) ret_at.push_back(cyc + LAT);
        i_vld = 1'b0;
        if (ret_at.size() != 0 && ret_at[0] == cyc) begin
            void'(ret_at.pop_front());
            i_vld  = 1'b1;
            i_data = rnd_data ? W'({$urandom, $urandom}) : W'(1000 + seq);
            seq++;
        end
        i_rdy = rdy;
        step();
    endtask

    task automatic fill(input int base);
        i_rdy = 1'b0;
        for (int t = 0; t < 22; t++) begin
            i_issue = (t < 16);
            i_vld   = (t >= LAT);
            i_data  = W'(base + t - LAT);
            step();
        end
        i_issue = 1'b0;
        i_vld   = 1'b0;
    endtask

    initial begin
        i_rst = 1'b1; i_issue = 1'b0; i_vld = 1'b0; i_data = '0; i_rdy = 1'b0;
        repeat (3) step();
        i_rst = 1'b0;
        repeat (3) step();
        chk("reset_vld", 64'(o_vld), 0);
        chk("reset_count", 64'(o_count), 0);
        chk("reset_inflight", 64'(o_inflight), 0);
        chk("reset_can_issue", 64'(o_can_issue), 1);
        chk("reset_flags", 64'({o_overflow, o_err}), 0);

        // Single round trip
        i_rdy = 1'b1;
        i_issue = 1'b1;
        step();
        i_issue = 1'b0;
        chk("rt_inflight1", 64'(o_inflight), 1);
        repeat (LAT - 1) step();
        i_vld = 1'b1; i_data = 49'h1_4000_0000_2000;
        step();
        i_vld = 1'b0;
        chk("rt_vld", 64'(o_vld), 1);
        chk("rt_data", 64'(o_data), 64'h1_4000_0000_2000);
        chk("rt_inflight0", 64'(o_inflight), 0);
        step();
        chk("rt_vld_gone", 64'(o_vld), 0);

        // Fill with consumer stalled, then drain in order
        fill(0);
        chk("fill_count", 64'(o_count), 16);
        chk("fill_can_issue", 64'(o_can_issue), 0);
        step();
        chk("fill_can_issue_hold", 64'(o_can_issue), 0);
        i_rdy = 1'b1;
        for (int k = 0; k < 16; k++) begin
            chk("fill_pop", 64'(o_data), 64'(k));
            step();
        end
        i_rdy = 1'b0;
        chk("fill_empty", 64'(o_count), 0);

        // Full with simultaneous read and write, then overflow
        fill(100);
        i_rdy = 1'b1; i_vld = 1'b1; i_data = W'(49'hAAAA);
        step();
        i_rdy = 1'b0; i_vld = 1'b0;
        chk("frw_count", 64'(o_count), 16);
        chk("frw_overflow", 64'(o_overflow), 0);
        chk("frw_head", 64'(o_data), 101);
        i_vld = 1'b1; i_data = 49'h0_DEAD_BEEF_0001;
        step();
        i_vld = 1'b0;
        chk("ovf_flag", 64'(o_overflow), 1);
        chk("ovf_count", 64'(o_count), 16);
        chk("ovf_err", 64'(o_err), 1);
        chk("ovf_head", 64'(o_data), 101);
        i_rdy = 1'b1;
        for (int k = 1; k < 16; k++) begin
            chk("frw_pop", 64'(o_data), 64'(100 + k));
            step();
        end
        chk("frw_last", 64'(o_data), 64'hAAAA);
        step();
        i_rdy = 1'b0;
        chk("frw_empty", 64'(o_count), 0);
        chk("ovf_sticky", 64'(o_overflow), 1);

        // Wrap: stream 40 words with the consumer toggling, reset at count 5
        i_rst = 1'b1; step(); i_rst = 1'b0;
        seq = 0;
        begin
            int issued = 0;
            int guard  = 0;
            bit hit    = 0;
            while ((issued < 40 || ret_at.size() != 0) && guard < 400) begin
                bit w;
                w = (issued < 40) && mcan();
                if (w) issued++;
                drive(w, guard[0] == 1'b0);
                guard++;
            end
            chk("wrap_stream_done", 64'(guard < 400), 1);
            chk("wrap_count_seen", 64'(seq), 40);
            guard = 0;
            while (!hit && guard < 200) begin
                if (m_q.size() == 5) hit = 1;
                else begin drive(1'b0, guard[0] == 1'b0); guard++; end
            end
            chk("wrap_reached5", 64'(hit), 1);
            chk("wrap_count5", 64'(o_count), 5);
        end
        i_rdy = 1'b0; i_issue = 1'b0; i_vld = 1'b0;
        i_rst = 1'b1; step(); i_rst = 1'b0;
        ret_at.delete();
        chk("rst_vld", 64'(o_vld), 0);
        chk("rst_data", 64'(o_data), 0);
        chk("rst_count", 64'(o_count), 0);
        chk("rst_inflight", 64'(o_inflight), 0);
        chk("rst_can_issue", 64'(o_can_issue), 1);
        chk("rst_overflow", 64'(o_overflow), 0);
        chk("rst_err", 64'(o_err), 0);

        // Randomized legal traffic
        rnd_data = 1;
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0);
        end
        for (int i = 0; i < 40; i++) drive(1'b0, 1'b1);
        chk("rnd_no_err", 64'({o_overflow, o_err}), 0);
        chk("rnd_drained", 64'({o_count, o_inflight}), 0);

        // Issue without credit
        fill(200);
        i_issue = 1'b1;
        step();
        i_issue = 1'b0;
        chk("nocredit_err", 64'(o_err), 1);
        chk("nocredit_inflight", 64'(o_inflight), 0);
        chk("nocredit_count", 64'(o_count), 16);
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cordic_result_fifo.md
Name: cordic_result_fifo

Overview:
- Downstream result buffer for the CORDIC core.
- Captures every `o_vld`/`o_data` beat from the core, which has no backpressure, into a first-word-fall-through FIFO.
- Presents the buffered results to the consumer over a valid/ready interface.
- Tracks requests in flight inside the core and gives the upstream issuer an issue-permit (credit) signal, so results are never dropped when the issuer obeys it.

Parameters:
- TOTAL_WIDTH, 49, result word width: bit 48 func, [47:32] X, [31:16] Y, [15:0] Z.
- DEPTH, 16, FIFO entries; power of two, ≥2.
- CNT_WIDTH, $clog2(DEPTH)+1, width of the occupancy and in-flight counters.

Ports:
- i_clk  input  1  clock; all logic on its rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_issue  input  1  upstream pulses this in the same cycle it asserts i_vld into the CORDIC core.
- o_can_issue  output  1  high when one more request may be issued.
- i_vld  input  1  result valid from the CORDIC core.
- i_data  input  TOTAL_WIDTH  result word from the CORDIC core.
- o_vld  output  1  head of FIFO valid.
- o_data  output  TOTAL_WIDTH  head of FIFO word.
- i_rdy  input  1  consumer accepts the head word.
- o_count  output  CNT_WIDTH  current FIFO occupancy, 0..DEPTH.
- o_inflight  output  CNT_WIDTH  requests issued and not yet returned.
- o_overflow  output  1  sticky: a result arrived with no free slot.
- o_err  output  1  sticky: protocol violation (issue without credit, or result with zero in-flight).

Behaviour:
- Clocking and reset
  - All state is updated on rising i_clk.
  - i_rst is sampled synchronously; it overrides every other event in the same cycle.
- Reset values: o_vld=0, o_data=0, o_count=0, o_inflight=0, o_overflow=0, o_err=0, o_can_issue=1. Read and write pointers = 0.
- Events per cycle
  - rd = o_vld & i_rdy.
  - wr = i_vld & (o_count<DEPTH | rd).
  - iss = i_issue & o_can_issue.
  - ret = i_vld.
- Storage
  - DEPTH×TOTAL_WIDTH array with read and write pointers of $clog2(DEPTH) bits.
  - Pointers wrap modulo DEPTH.
  - wr writes i_data at the write pointer, then increments it.
  - rd increments the read pointer.
- Output path
  - First-word-fall-through: o_vld = (o_count!=0).
  - o_data = array[read pointer] while o_vld=1, otherwise 0.
  - o_data must not change while o_vld=1 and i_rdy=0.
- Latency: a word written in cycle N appears on o_vld/o_data in cycle N+1, when the FIFO was empty.
- Occupancy
  - o_count += wr − rd, registered.
  - Full with simultaneous i_vld and rd: write accepted, count stays DEPTH, no overflow.
  - Empty with i_vld: no read is possible that cycle (o_vld=0), so no pass-through.
- Overflow
  - i_vld while o_count==DEPTH and !rd drops the word.
  - Count and pointers are unchanged; o_overflow set to 1 until reset.
- In-flight counter
  - o_inflight += iss − ret, registered.
  - iss and ret in the same cycle leave it unchanged.
  - ret with o_inflight==0: counter holds at 0 and o_err is set. The word itself is still written if there is room.
  - i_issue while o_can_issue=0: not counted, o_err is set.
- Credit
  - o_can_issue = (o_count + o_inflight) < DEPTH, computed from the registered counters (combinational from registers, no lookahead).
  - Invariant under legal use: o_count + o_inflight ≤ DEPTH, so o_overflow never sets.
- Reset mid-operation: FIFO contents are discarded and in-flight requests are forgotten. Results that return from the core after reset are counted as o_err.
- Arithmetic: all counters are unsigned CNT_WIDTH and never wrap. The o_count sum is computed in CNT_WIDTH+1 bits.

Test Plan:
- Reset then idle → o_vld=0, o_count=0, o_inflight=0, o_can_issue=1, flags 0.
- Single round trip
  - Stimulus: issue 1; 6 cycles later i_vld with i_data=49'h1_4000_0000_2000; i_rdy=1.
  - Response: o_inflight goes 1 then 0; o_vld high exactly one cycle with that word.
- Fill with i_rdy=0
  - Stimulus: issue 16 requests, each returned with data = index 0..15.
  - Response: after the 16th issue o_can_issue=0 until the first pop. Then raise i_rdy; words pop in order 0..15, o_count drops to 0.
- Full plus simultaneous read and write
  - Stimulus: o_count=16, i_rdy=1 and i_vld=1 in the same cycle.
  - Response: o_count stays 16, no overflow, the new word is read out last.
- Overflow
  - Stimulus: o_count=16, i_rdy=0, i_vld with 49'h0_DEAD_BEEF_0001.
  - Response: word dropped, o_overflow=1 and sticky, o_count=16, o_err=1 (inflight was 0).
- Wrap and reset
  - Stimulus: stream 40 words at 1/cycle with i_rdy toggling 1,0, then assert i_rst with o_count=5.
  - Response: pointers wrap and data order is preserved. The next cycle shows all outputs at their reset values.
